// File: rtl/k423_if_fetch.sv
// k423 instruction fetch: owns the fetch PC, issues credit-limited word requests and queues {pc, inst} for decode.
// Latency: grant in N, rvalid in N+1, decode sees it in N+2; id_rdy_i low fills the buffer and stops requests.

module k423_if_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          push_i,
   input  logic [W-1:0]  push_dat_i,
   input  logic          pop_i,
   output logic [W-1:0]  head_dat_o,
   output logic [CW-1:0] cnt_o
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop_i & (cnt_q != '0);
   assign do_push = push_i & ((cnt_q != FULL) | do_pop);

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (clr_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = push_dat_i;
            wr_d        = wr_q + 1'b1;
         end
         if (do_pop) begin
            rd_d = rd_q + 1'b1;
         end
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_dat_o = (cnt_q != '0) ? mem_q[rd_q] : '0;
   assign cnt_o      = cnt_q;
endmodule

module k423_if_fetch #(
   parameter int                 CORE_XLEN   = 32,
   parameter int                 CORE_INST_W = 32,
   parameter logic [CORE_XLEN-1:0] RESET_PC  = 32'h8000_0000,
   parameter int                 FIFO_DEPTH  = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   output logic                   imem_req_o,
   output logic [CORE_XLEN-1:0]   imem_addr_o,
   input  logic                   imem_gnt_i,
   input  logic                   imem_rvalid_i,
   input  logic [CORE_INST_W-1:0] imem_rdata_i,
   input  logic                   redirect_vld_i,
   input  logic [CORE_XLEN-1:0]   redirect_pc_i,
   output logic                   if_vld_o,
   output logic [CORE_INST_W-1:0] if_inst_o,
   output logic [CORE_XLEN-1:0]   if_pc_o,
   input  logic                   id_rdy_i
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [CORE_XLEN-1:0]   pc;
      logic [CORE_INST_W-1:0] inst;
   } fetch_ent_t;

   typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

   state_e               state_q, state_d;
   logic [CORE_XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]        drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]        os_cnt, os_left, fifo_cnt;
   logic [CORE_XLEN-1:0] pcq_head;
   fetch_ent_t           push_ent, head_ent;
   logic                 gnt, rsp, drop_hit, keep, deq, credit_ok;
   logic                 redir_lsb_unused;

   assign redir_lsb_unused = ^redirect_pc_i[1:0];

   // The PC queue occupancy is the outstanding-request count.
   assign gnt       = imem_req_o & imem_gnt_i;
   assign rsp       = imem_rvalid_i & (os_cnt != '0);
   assign os_left   = os_cnt - CW'(rsp);
   assign drop_hit  = rsp & (drop_cnt_q != '0);
   assign keep      = rsp & ~drop_hit & ~redirect_vld_i;
   assign deq       = if_vld_o & id_rdy_i & ~redirect_vld_i;
   assign credit_ok = ({1'b0, os_cnt} + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH);

   assign imem_req_o  = (state_q != BOOT) & ~redirect_vld_i & credit_ok;
   assign imem_addr_o = pc_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_cnt_d = drop_cnt_q;
      if (drop_hit) begin
         drop_cnt_d = drop_cnt_q - 1'b1;
      end
      if (gnt) begin
         pc_d = pc_q + CORE_XLEN'(4);
      end
      // Everything still in flight after this cycle's response becomes stale.
      if (redirect_vld_i) begin
         pc_d       = {redirect_pc_i[CORE_XLEN-1:2], 2'b00};
         drop_cnt_d = os_left;
      end
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (redirect_vld_i && (os_left != '0)) state_d = FLUSH;
         FLUSH:   if (drop_cnt_d == '0) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   k423_if_fifo #(.W(CORE_XLEN), .DEPTH(FIFO_DEPTH), .CW(CW)) u_pc_q (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (1'b0),
      .push_i     (gnt),
      .push_dat_i (pc_q),
      .pop_i      (rsp),
      .head_dat_o (pcq_head),
      .cnt_o      (os_cnt)
   );

   assign push_ent.pc   = pcq_head;
   assign push_ent.inst = imem_rdata_i;

   k423_if_fifo #(.W($bits(fetch_ent_t)), .DEPTH(FIFO_DEPTH), .CW(CW)) u_inst_q (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (redirect_vld_i),
      .push_i     (keep),
      .push_dat_i (push_ent),
      .pop_i      (deq),
      .head_dat_o (head_ent),
      .cnt_o      (fifo_cnt)
   );

   assign if_vld_o  = (fifo_cnt != '0);
   assign if_pc_o   = head_ent.pc;
   assign if_inst_o = head_ent.inst;
endmodule
